// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file with same-cycle
// write-through bypass on the decode read ports, a debug read port and a write counter.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] MEM_WB_RegWriteAddr,
  input  logic [DATA_W-1:0] MEM_WB_ALUOut,
  input  logic [DATA_W-1:0] MEM_WB_Read_Data,
  input  logic [DATA_W-1:0] MEM_WB_PC_4,
  input  logic [1:0]        MEM_WB_MemtoReg,
  input  logic              MEM_WB_RegWrite,
  input  logic [ADDR_W-1:0] ID_ReadAddr1,
  input  logic [ADDR_W-1:0] ID_ReadAddr2,
  output logic [DATA_W-1:0] ID_ReadData1,
  output logic [DATA_W-1:0] ID_ReadData2,
  output logic [DATA_W-1:0] WB_WriteData,
  output logic              WB_WriteEn,
  input  logic [ADDR_W-1:0] Dbg_Addr,
  output logic [DATA_W-1:0] Dbg_Data,
  output logic [CNT_W-1:0]  WB_Count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_en;
  logic              w_bypass_en;

  always_comb begin
    w_wb_data = '0;
    case (MEM_WB_MemtoReg)
      2'b00:   w_wb_data = MEM_WB_ALUOut;
      2'b01:   w_wb_data = MEM_WB_Read_Data;
      2'b10:   w_wb_data = MEM_WB_PC_4;
      default: w_wb_data = '0;
    endcase
  end

  // Logical && keeps an X on MemtoReg from leaking into the strobe when RegWrite=0.
  assign w_wb_en = MEM_WB_RegWrite && (MEM_WB_RegWriteAddr != '0) &&
                   (MEM_WB_MemtoReg != 2'b11);

  // While in reset nothing may be forwarded, so the bypass also requires rst high.
  assign w_bypass_en = w_wb_en && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_count <= '0;
    end else if (w_wb_en) begin
      r_regs[MEM_WB_RegWriteAddr] <= w_wb_data;
      r_count                     <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    ID_ReadData1 = '0;
    if (ID_ReadAddr1 == '0)
      ID_ReadData1 = '0;
    else if (w_bypass_en && (ID_ReadAddr1 == MEM_WB_RegWriteAddr))
      ID_ReadData1 = w_wb_data;
    else
      ID_ReadData1 = r_regs[ID_ReadAddr1];
  end

  always_comb begin
    ID_ReadData2 = '0;
    if (ID_ReadAddr2 == '0)
      ID_ReadData2 = '0;
    else if (w_bypass_en && (ID_ReadAddr2 == MEM_WB_RegWriteAddr))
      ID_ReadData2 = w_wb_data;
    else
      ID_ReadData2 = r_regs[ID_ReadAddr2];
  end

  assign Dbg_Data     = (Dbg_Addr == '0) ? '0 : r_regs[Dbg_Addr];
  assign WB_WriteData = w_wb_data;
  assign WB_WriteEn   = w_wb_en;
  assign WB_Count     = r_count;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back stage and architectural register file, directly downstream of the MEM/WB pipeline register.
- Selects the write-back value from the ALU result, memory read data or PC+4, and writes it into a 32-entry register file on the clock edge.
- Serves the two decode-stage read ports with same-cycle write-through bypass.
- Provides a debug read port and a write-back event counter for bring-up.

Parameters:
- DATA_W, 32, width of each register and of every datapath port.
- ADDR_W, 5, register address width; the file has 2**ADDR_W entries.
- CNT_W, 32, width of the write-back event counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- MEM_WB_RegWriteAddr  input  ADDR_W  destination register.
- MEM_WB_ALUOut  input  DATA_W  ALU result.
- MEM_WB_Read_Data  input  DATA_W  load data.
- MEM_WB_PC_4  input  DATA_W  return address for link instructions.
- MEM_WB_MemtoReg  input  2  write-back source: 00 ALUOut, 01 Read_Data, 10 PC_4, 11 reserved.
- MEM_WB_RegWrite  input  1  write enable.
- ID_ReadAddr1  input  ADDR_W  read port 1 address (rs).
- ID_ReadAddr2  input  ADDR_W  read port 2 address (rt).
- ID_ReadData1  output  DATA_W  read port 1 data, combinational.
- ID_ReadData2  output  DATA_W  read port 2 data, combinational.
- WB_WriteData  output  DATA_W  selected write-back value, combinational; also used by EX forwarding.
- WB_WriteEn  output  1  effective write strobe, combinational.
- Dbg_Addr  input  ADDR_W  debug read address.
- Dbg_Data  output  DATA_W  debug read data, combinational, no bypass.
- WB_Count  output  CNT_W  number of effective writes since reset.

Behaviour:
- Write-back mux:
  - MemtoReg 00 selects ALUOut, 01 selects Read_Data, 10 selects PC_4.
  - MemtoReg 11 gives WB_WriteData = 0, and no write occurs.
- Effective write: WB_WriteEn = RegWrite AND (addr != 0) AND (MemtoReg != 11).
- Write timing: on the rising clk edge with WB_WriteEn=1, reg[addr] <= WB_WriteData. The value is visible on the read ports in the same cycle through the bypass, and from storage in following cycles.
- Register 0:
  - Always reads 0 on every port.
  - Writes to it are discarded and not counted.
- Read ports:
  - ID_ReadDataN = 0 if ID_ReadAddrN == 0.
  - Else WB_WriteData if WB_WriteEn and ID_ReadAddrN == MEM_WB_RegWriteAddr.
  - Else reg[ID_ReadAddrN].
  - Both ports may hit the bypass in the same cycle.
- Debug port: Dbg_Data = reg[Dbg_Addr] from storage only (0 for address 0). It shows the new value one edge after the write.
- Counter:
  - WB_Count increments by 1 on each edge where WB_WriteEn=1.
  - Wraps from 2**CNT_W-1 to 0 with no flag.
- Reset (rst=0):
  - Asynchronously clears all registers and WB_Count to 0, independent of clk.
  - While rst=0, writes and counting are blocked; read and debug ports return 0.
  - On deassertion, the first write occurs on the first rising edge with rst=1.
  - A write coincident with reset assertion is lost.
- No internal pipeline stage: latency from MEM_WB inputs to storage is one edge; to read/forward outputs it is zero cycles.
- Inputs with X on MemtoReg while RegWrite=0 must not corrupt state.

Test Plan:
- Reset: hold rst=0 for 3 cycles with RegWrite=1, addr=5 -> reg[5]=0, WB_Count=0, ID_ReadData1 (addr 5)=0; release, then one write -> WB_Count=1.
- Source select: write addr 3 with MemtoReg=00/01/10 on ALUOut=0x11111111, Read_Data=0x22222222, PC_4=0x00400008 -> Dbg_Data for addr 3 reads 0x11111111, 0x22222222, 0x00400008 after each edge.
- Register 0 and reserved: RegWrite=1, addr=0, ALUOut=0xDEADBEEF -> reads 0, WB_Count unchanged; MemtoReg=11, addr=7 -> WB_WriteEn=0, reg[7] unchanged.
- Bypass: reg[8]=0x5; same cycle RegWrite=1, addr=8, ALUOut=0xABCD, ID_ReadAddr1=ID_ReadAddr2=8 -> both read 0xABCD before the edge; Dbg_Data for 8 reads 0x5 before the edge and 0xABCD after.
- Back-to-back writes: addr 9 gets 0x1 then 0x2 on consecutive edges with read port 1 on addr 9 -> sees 0x1 then 0x2 with no stale cycle; WB_Count +2.
- Mid-run reset: after 10 writes, pulse rst=0 between edges -> all reads and WB_Count go to 0 immediately, without waiting for clk.
